// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, blank code and BCD moduli for the timekeeper
package clock_pkg;
  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [3:0] DIGIT_BLANK   = 4'hF;
  // Moduli are held BCD-encoded so they compare directly against {tens, ones}
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a raw button, debounces it and emits one pulse per accepted press
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk1khz,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  logic [1:0] sync_q;
  logic level_q, level_d, press_q, press_d, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // Count consecutive samples that disagree with the accepted level; accept on the last one
  always_comb begin
    done = sync_q[1] != level_q && cnt_q == CW'(DEBOUNCE_MS - 1);
    cnt_d = (sync_q[1] == level_q || done) ? '0 : cnt_q + 1'b1;
    level_d = done ? sync_q[1] : level_q;
    press_d = done && sync_q[1];
  end
  // Synchronizer, debounce state and registered press pulse
  always_ff @(posedge clk1khz) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 24-hour BCD clock with button set modes and field blink; hourly chime under BCD_TIMEKEEPER_CHIME_EN
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int CHIME_SECS  = 3
) (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] q4,
  output logic [3:0] q5,
  output logic [1:0] set_mode,
  output logic       chime
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
  logic [3:0] s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
  logic mode_p, inc_p, tick, blink_off, run_tick;
  logic sec_top, min_top, hr_top, sec_inc, min_inc, hr_inc;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
    .clk1khz(clk1khz), .rst(rst), .key_i(key_mode), .press_o(mode_p)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc (
    .clk1khz(clk1khz), .rst(rst), .key_i(key_inc), .press_o(inc_p)
  );

  // Prescaler, BCD carry chain and mode sequencing; a mode press masks a same-cycle inc
  always_comb begin
    tick = pre_q == PRE_LAST;
    pre_d = tick ? '0 : pre_q + 1'b1;
    blink_off = pre_q >= PRE_HALF;
    run_tick = tick && mode_q == MODE_RUN;
    sec_top = {s1_q, s0_q} == SEC_MAX;
    min_top = {m1_q, m0_q} == MIN_MAX;
    hr_top = {h1_q, h0_q} == HOUR_MAX;
    sec_inc = run_tick;
    min_inc = (run_tick && sec_top) || (inc_p && !mode_p && mode_q == MODE_SET_MIN);
    hr_inc = (run_tick && sec_top && min_top) || (inc_p && !mode_p && mode_q == MODE_SET_HOUR);
    s0_d = sec_inc ? (s0_q == 4'd9 ? 4'd0 : s0_q + 4'd1) : s0_q;
    s1_d = (sec_inc && s0_q == 4'd9) ? (sec_top ? 4'd0 : s1_q + 4'd1) : s1_q;
    m0_d = min_inc ? (m0_q == 4'd9 ? 4'd0 : m0_q + 4'd1) : m0_q;
    m1_d = (min_inc && m0_q == 4'd9) ? (min_top ? 4'd0 : m1_q + 4'd1) : m1_q;
    h0_d = hr_inc ? ((hr_top || h0_q == 4'd9) ? 4'd0 : h0_q + 4'd1) : h0_q;
    h1_d = (hr_inc && (hr_top || h0_q == 4'd9)) ? (hr_top ? 4'd0 : h1_q + 4'd1) : h1_q;
    mode_d = !mode_p ? mode_q :
             mode_q == MODE_RUN ? MODE_SET_HOUR :
             mode_q == MODE_SET_HOUR ? MODE_SET_MIN : MODE_RUN;
    if (mode_p && mode_q == MODE_RUN) begin
      s0_d = 4'd0;
      s1_d = 4'd0;
    end
  end

  // Time, mode and prescaler registers
  always_ff @(posedge clk1khz) begin
    if (rst) begin
      pre_q  <= '0;
      mode_q <= MODE_RUN;
      {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
    end else begin
      pre_q  <= pre_d;
      mode_q <= mode_d;
      {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d};
    end
  end

  assign q0 = s0_q;
  assign q1 = s1_q;
  assign q2 = (mode_q == MODE_SET_MIN && blink_off) ? DIGIT_BLANK : m0_q;
  assign q3 = (mode_q == MODE_SET_MIN && blink_off) ? DIGIT_BLANK : m1_q;
  assign q4 = (mode_q == MODE_SET_HOUR && blink_off) ? DIGIT_BLANK : h0_q;
  assign q5 = (mode_q == MODE_SET_HOUR && blink_off) ? DIGIT_BLANK : h1_q;
  assign set_mode = mode_q;

`ifdef BCD_TIMEKEEPER_CHIME_EN
  localparam int CCW = $clog2(CHIME_SECS + 1);
  logic chime_q;
  logic [CCW-1:0] ccnt_q;
  // Chime raised on the hour rollover, dropped after CHIME_SECS more ticks or on leaving RUN
  always_ff @(posedge clk1khz) begin
    if (rst || (mode_p && mode_q == MODE_RUN)) begin
      chime_q <= 1'b0;
      ccnt_q  <= '0;
    end else if (run_tick && sec_top && min_top) begin
      chime_q <= 1'b1;
      ccnt_q  <= CCW'(CHIME_SECS);
    end else if (run_tick && chime_q) begin
      ccnt_q  <= ccnt_q - 1'b1;
      chime_q <= ccnt_q != CCW'(1);
    end
  end
  assign chime = chime_q;
`else
  assign chime = 1'b0 & |CHIME_SECS;
`endif
endmodule
